// File: rtl/ts_channel_scheduler.sv
// Purpose : packet-aligned 4-channel TS scheduler; drives the mux select and qualifies the muxed valid into the output FIFO.
// Latency : valid_gate is combinational (zero latency); mux_ctrl and the pulse outputs update one edge after the deciding cycle.
// Backpr. : none; bytes not gated are dropped, and a channel that stays idle for TIMEOUT cycles is replaced.
// Ports   : wclk/rst (sync, active-high); enable; req_sel/req_load (channel request strobe);
//           valid_in/sync_in (per-channel byte flags); mux_ctrl (select); valid_gate (FIFO write qualifier);
//           switching/sync_err/timeout_err (one-cycle event pulses).
module ts_channel_scheduler #(
  parameter int PKT_LEN = 188,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 4096,
  parameter int TMR_W   = 13
) (
  input  logic       wclk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] req_sel,
  input  logic       req_load,
  input  logic [3:0] valid_in,
  input  logic [3:0] sync_in,
  output logic [1:0] mux_ctrl,
  output logic       valid_gate,
  output logic       switching,
  output logic       sync_err,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, SEEK, PASS, SWITCH} state_t;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PKT_LEN - 1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [1:0]       tgt, tgt_nxt, mux_nxt;
  logic             pending, pending_nxt, clr_pending;
  logic [CNT_W-1:0] byte_cnt, cnt_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             sw_nxt, serr_nxt, terr_nxt;
  logic             sv, ss, idle_tick, tmo;

  assign sv        = valid_in[mux_ctrl];
  assign ss        = sync_in[mux_ctrl];
  assign idle_tick = ((state == SEEK) || (state == PASS)) && !sv;
  // Fires on the TIMEOUT-th consecutive idle cycle of the selected channel.
  assign tmo       = idle_tick && (timer == TMO_LAST);

  always_comb begin
    state_nxt   = state;
    mux_nxt     = mux_ctrl;
    cnt_nxt     = byte_cnt;
    valid_gate  = 1'b0;
    sw_nxt      = 1'b0;
    serr_nxt    = 1'b0;
    terr_nxt    = 1'b0;
    clr_pending = 1'b0;

    case (state)
      IDLE: begin
        if (enable) state_nxt = SEEK;
      end
      SEEK: begin
        valid_gate = sv & ss;
        // A sync start beats a pending switch; the switch then waits for the packet end.
        if (sv && ss) begin
          state_nxt = PASS;
          cnt_nxt   = CNT_W'(1);
        end else if (pending) begin
          state_nxt = SWITCH;
        end else if (!enable) begin
          state_nxt = IDLE;
        end
      end
      PASS: begin
        if (sv) begin
          if ((byte_cnt == '0) && !ss) begin
            // Expected a sync byte but got data: alignment lost, drop the byte.
            serr_nxt  = 1'b1;
            state_nxt = SEEK;
          end else begin
            valid_gate = 1'b1;
            if (ss && (byte_cnt != '0)) begin
              // Early sync: treat as a new packet start.
              serr_nxt = 1'b1;
              cnt_nxt  = CNT_W'(1);
            end else if (byte_cnt == LAST_BYTE) begin
              cnt_nxt = '0;
              if (pending)      state_nxt = SWITCH;
              else if (!enable) state_nxt = IDLE;
            end else begin
              cnt_nxt = byte_cnt + 1'b1;
            end
          end
        end
      end
      SWITCH: begin
        mux_nxt     = tgt;
        clr_pending = 1'b1;
        sw_nxt      = 1'b1;
        state_nxt   = SEEK;
        cnt_nxt     = '0;
      end
      default: state_nxt = IDLE;
    endcase

    // Failover overrides whatever the state machine decided this cycle.
    if (tmo) begin
      terr_nxt    = 1'b1;
      sw_nxt      = 1'b1;
      state_nxt   = SEEK;
      cnt_nxt     = '0;
      clr_pending = 1'b1;
      mux_nxt     = pending ? tgt : (mux_ctrl + 2'd1);
    end

    // A request arriving while the select moves is judged against the new select.
    tgt_nxt     = req_load ? req_sel : tgt;
    pending_nxt = req_load ? (req_sel != mux_nxt) : (pending && !clr_pending);

    timer_nxt = (idle_tick && (state_nxt == state) && (mux_nxt == mux_ctrl))
                ? (timer + 1'b1) : '0;
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      state       <= IDLE;
      mux_ctrl    <= 2'd0;
      tgt         <= 2'd0;
      pending     <= 1'b0;
      byte_cnt    <= '0;
      timer       <= '0;
      switching   <= 1'b0;
      sync_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      mux_ctrl    <= mux_nxt;
      tgt         <= tgt_nxt;
      pending     <= pending_nxt;
      byte_cnt    <= cnt_nxt;
      timer       <= timer_nxt;
      switching   <= sw_nxt;
      sync_err    <= serr_nxt;
      timeout_err <= terr_nxt;
    end
  end

endmodule
